write_buffer: RTL and testbench

- Upstream feeder of the memory read path. Accepts a byte stream from the acquisition/packetizer logic, packs byte pairs into 16-bit words (first byte in [7:0], second in [15:8]), and queues them in a small word FIFO.
- Drains the FIFO to the memory controller with a request/acknowledge handshake.
- Publishes ROW_WRITE, the count of completed memory rows, which downstream readers use to gate their start.

---
 rtl/write_buffer.sv | 80 ++++++++
 tb/tb_write_buffer.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/write_buffer.sv
// write_buffer: packs byte pairs into 16-bit words, queues them in a small FIFO
// and drains them to the memory controller while tracking the row/column written.
module write_buffer #(
  parameter int FIFO_DEPTH = 4,
  parameter int WORDS_PER_ROW = 512,
  parameter int ROW_MAX = 8191,
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic        CLK_48MHZ,
  input  logic        RESET,
  input  logic [7:0]  BYTE_IN,
  input  logic        BYTE_VALID,
  output logic        BYTE_READY,
  input  logic        FLUSH,
  output logic        WRITE_CMD,
  output logic [15:0] WRITE_DATA,
  input  logic        WRITE_ACK,
  output logic [12:0] ROW_WRITE,
  output logic [8:0]  COL_WRITE,
  output logic        MEM_FULL,
  output logic        OVERFLOW
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, GAP} state_t;
  state_t state, state_next;
  logic [15:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [7:0] low;
  logic pend, flush_pend, accept, flush_req, push, pop, last_col;
  logic [15:0] push_data;
  assign BYTE_READY = count != (AW+1)'(FIFO_DEPTH);
  assign accept = BYTE_VALID && BYTE_READY;
  assign flush_req = FLUSH || flush_pend;
  // a flush that finds the FIFO full stays armed in flush_pend until space frees
  assign push = BYTE_READY && (accept ? (pend || flush_req) : (pend && flush_req));
  assign push_data = accept ? (pend ? {BYTE_IN, low} : {PAD_BYTE, BYTE_IN}) : {PAD_BYTE, low};
  assign pop = state == REQ && WRITE_ACK;
  assign WRITE_CMD = state == REQ;
  assign MEM_FULL = ROW_WRITE == 13'(ROW_MAX);
  assign last_col = COL_WRITE == 9'(WORDS_PER_ROW - 1);
  always_comb begin
    state_next = state == IDLE ? ((count != '0 && !MEM_FULL) ? REQ : IDLE) :
                 state == REQ  ? (WRITE_ACK ? GAP : REQ) : IDLE;
  end
  always_ff @(posedge CLK_48MHZ) begin
    if (!RESET) state <= IDLE;
    else state <= state_next;
  end
  always_ff @(posedge CLK_48MHZ) begin
    if (push) mem[wr_ptr] <= push_data;
  end
  always_ff @(posedge CLK_48MHZ) begin
    if (!RESET) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      pend <= 1'b0;
      flush_pend <= 1'b0;
      low <= '0;
      WRITE_DATA <= '0;
      ROW_WRITE <= '0;
      COL_WRITE <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      wr_ptr <= wr_ptr + AW'(push);
      rd_ptr <= rd_ptr + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      pend <= accept ? (!pend && !flush_req) : (pend && !(flush_req && BYTE_READY));
      flush_pend <= pend && flush_req && !BYTE_READY;
      if (accept && !pend) low <= BYTE_IN;
      if (state == IDLE && state_next == REQ) WRITE_DATA <= mem[rd_ptr];
      OVERFLOW <= OVERFLOW || (BYTE_VALID && !BYTE_READY);
      if (pop) begin
        COL_WRITE <= last_col ? '0 : COL_WRITE + 9'd1;
        if (last_col && !MEM_FULL) ROW_WRITE <= ROW_WRITE + 13'd1;
      end
    end
  end
endmodule

// File: tb/tb_write_buffer.sv
// tb_write_buffer: directed vectors plus random traffic scored against a queue-level model.
module tb_write_buffer;
  logic clk = 0, rst_n = 0, byte_valid = 0, flush = 0, write_ack = 0;
  logic [7:0] byte_in = 0;
  logic byte_ready, write_cmd, mem_full, overflow;
  logic [15:0] write_data;
  logic [12:0] row_write;
  logic [8:0] col_write;
  logic s_rst = 0, s_valid = 0, s_flush = 0, s_ack = 0;
  logic [7:0] s_byte = 0;
  logic s_ready, s_cmd, s_full, s_ovf;
  logic [15:0] s_data;
  logic [12:0] s_row;
  logic [8:0] s_col;
  int n_cmp = 0, n_fail = 0;
  logic [15:0] mq[$];
  logic m_pend = 0, m_fpend = 0, m_ovf = 0;
  logic [7:0] m_low = 0;
  int acks = 0, quiet = 0;

  write_buffer u0 (
    .CLK_48MHZ(clk), .RESET(rst_n), .BYTE_IN(byte_in), .BYTE_VALID(byte_valid),
    .BYTE_READY(byte_ready), .FLUSH(flush), .WRITE_CMD(write_cmd), .WRITE_DATA(write_data),
    .WRITE_ACK(write_ack), .ROW_WRITE(row_write), .COL_WRITE(col_write),
    .MEM_FULL(mem_full), .OVERFLOW(overflow)
  );
  write_buffer #(.FIFO_DEPTH(4), .WORDS_PER_ROW(4), .ROW_MAX(2)) u1 (
    .CLK_48MHZ(clk), .RESET(s_rst), .BYTE_IN(s_byte), .BYTE_VALID(s_valid),
    .BYTE_READY(s_ready), .FLUSH(s_flush), .WRITE_CMD(s_cmd), .WRITE_DATA(s_data),
    .WRITE_ACK(s_ack), .ROW_WRITE(s_row), .COL_WRITE(s_col),
    .MEM_FULL(s_full), .OVERFLOW(s_ovf)
  );

  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic reset_u0();
    rst_n = 0; byte_valid = 0; flush = 0; write_ack = 0; byte_in = 0;
    @(posedge clk); #1;
    mq.delete(); m_pend = 0; m_fpend = 0; m_ovf = 0; acks = 0; quiet = 0;
    rst_n = 1;
  endtask

  // one cycle: score current outputs, drive inputs, advance the model to the next edge
  task automatic step(input logic v, input logic [7:0] b, input logic f, input logic a);
    logic rdy, acc, fr;
    logic [15:0] tmp;
    if (quiet > 0) begin check("gap_cmd", write_cmd, 0); quiet--; end
    if (write_cmd) begin
      if (mq.size() == 0) check("cmd_with_empty_model", 1, 0);
      else check("wdata", write_data, mq[0]);
    end
    check("ready", byte_ready, mq.size() != 4);
    check("col", col_write, acks % 512);
    check("row", row_write, acks / 512);
    byte_valid = v; byte_in = b; flush = f; write_ack = a;
    rdy = mq.size() != 4; acc = v && rdy; fr = f || m_fpend;
    if (v && !rdy) m_ovf = 1;
    if (write_cmd && a && mq.size() > 0) begin tmp = mq.pop_front(); acks++; quiet = 2; end
    if (acc && m_pend) begin mq.push_back({b, m_low}); m_pend = 0; m_fpend = 0; end
    else if (acc && fr) begin mq.push_back({8'h00, b}); m_fpend = 0; end
    else if (acc) begin m_low = b; m_pend = 1; end
    else if (m_pend && fr && rdy) begin mq.push_back({8'h00, m_low}); m_pend = 0; m_fpend = 0; end
    else m_fpend = m_pend && fr;
    @(posedge clk); #1;
    check("overflow", overflow, m_ovf);
  endtask

  typedef struct {
    logic v; logic [7:0] b; logic f; logic a;
    logic cmd; logic [15:0] data; logic [8:0] col;
  } vec_t;
  vec_t tv[14];

  initial begin
    int n, last_rise, rises, gap_bad, cyc, sa, sb, cmds;
    logic prev, got, acc;
    tv[0]  = '{1, 8'h11, 0, 0, 0, 16'h0000, 0};
    tv[1]  = '{1, 8'h22, 0, 0, 0, 16'h0000, 0};
    tv[2]  = '{0, 8'h00, 0, 0, 1, 16'h2211, 0};
    tv[3]  = '{0, 8'h00, 0, 0, 1, 16'h2211, 0};
    tv[4]  = '{0, 8'h00, 0, 1, 0, 16'h0000, 1};
    tv[5]  = '{0, 8'h00, 0, 0, 0, 16'h0000, 1};
    tv[6]  = '{1, 8'hAB, 0, 0, 0, 16'h0000, 1};
    tv[7]  = '{0, 8'h00, 1, 0, 0, 16'h0000, 1};
    tv[8]  = '{0, 8'h00, 0, 0, 1, 16'h00AB, 1};
    tv[9]  = '{0, 8'h00, 0, 1, 0, 16'h0000, 2};
    tv[10] = '{0, 8'h00, 0, 0, 0, 16'h0000, 2};
    tv[11] = '{0, 8'h00, 1, 0, 0, 16'h0000, 2};
    tv[12] = '{0, 8'h00, 0, 0, 0, 16'h0000, 2};
    tv[13] = '{0, 8'h00, 0, 0, 0, 16'h0000, 2};

    reset_u0();
    check("rst_cmd", write_cmd, 0);
    check("rst_data", write_data, 0);
    check("rst_row", row_write, 0);
    check("rst_col", col_write, 0);
    check("rst_full", mem_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_ready", byte_ready, 1);
    for (int i = 0; i < 14; i++) begin
      step(tv[i].v, tv[i].b, tv[i].f, tv[i].a);
      check($sformatf("tv%0d_cmd", i), write_cmd, tv[i].cmd);
      if (tv[i].cmd) check($sformatf("tv%0d_data", i), write_data, tv[i].data);
      check($sformatf("tv%0d_col", i), col_write, tv[i].col);
    end

    // stall the controller and overrun the FIFO
    reset_u0();
    for (int i = 1; i <= 8; i++) step(1, 8'(i), 0, 0);
    check("full_ready", byte_ready, 0);
    check("full_ovf_before", overflow, 0);
    step(1, 8'd9, 0, 0);
    step(1, 8'd10, 0, 0);
    check("ovf_set", overflow, 1);
    check("stall_cmd", write_cmd, 1);
    check("stall_data", write_data, 16'h0201);
    for (int i = 0; i < 16; i++) step(0, 0, 0, 1);
    check("drain_col", col_write, 4);
    check("ovf_sticky", overflow, 1);

    // random traffic
    reset_u0();
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1);
    step(0, 0, 1, 1);
    for (int i = 0; i < 30; i++) step(0, 0, 0, 1);
    check("rand_drained", mq.size(), 0);
    check("rand_idle_cmd", write_cmd, 0);

    // two full rows at maximum rate
    reset_u0();
    last_rise = -1; rises = 0; gap_bad = 0; cyc = 0; prev = 0;
    while (acks < 1024 && cyc < 4000) begin
      step(1, 8'($urandom), 0, 1);
      cyc++;
      if (write_cmd && !prev) begin
        if (last_rise >= 0 && cyc - last_rise != 3) gap_bad++;
        last_rise = cyc; rises++;
      end
      prev = write_cmd;
      if (acks == 512 && quiet == 2) begin
        check("row_at_512", row_write, 1);
        check("col_at_512", col_write, 0);
      end
    end
    check("stream_done", acks, 1024);
    check("row_at_1024", row_write, 2);
    check("col_at_1024", col_write, 0);
    check("req_spacing_bad", gap_bad, 0);
    check("req_count", rises, 1024);

    // reset in the middle of a handshake
    reset_u0();
    step(1, 8'h11, 0, 1); step(1, 8'h22, 0, 1); step(1, 8'h33, 0, 1); step(1, 8'h44, 0, 1);
    n = 0;
    while (!(write_cmd && col_write == 1) && n < 20) begin step(0, 0, 0, col_write == 0); n++; end
    check("reach_req", n < 20, 1);
    rst_n = 0; byte_valid = 0; write_ack = 0;
    @(posedge clk); #1;
    check("midrst_cmd", write_cmd, 0);
    check("midrst_col", col_write, 0);
    check("midrst_row", row_write, 0);
    check("midrst_ready", byte_ready, 1);
    mq.delete(); m_pend = 0; m_fpend = 0; m_ovf = 0; acks = 0; quiet = 0;
    rst_n = 1;
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
    check("midrst_empty", write_cmd, 0);
    step(1, 8'h01, 0, 0); step(1, 8'h02, 0, 0); step(0, 0, 0, 0);
    check("post_rst_cmd", write_cmd, 1);
    check("post_rst_data", write_data, 16'h0201);

    // small geometry: saturation at ROW_MAX
    s_rst = 0;
    @(posedge clk); #1;
    s_rst = 1;
    check("s_rst_full", s_full, 0);
    sa = 0; sb = 0;
    for (int c = 0; c < 200 && sa < 8; c++) begin
      s_valid = s_ready; s_byte = sb[7:0]; s_ack = 1;
      if (s_cmd) check("s_wdata", s_data, {8'(2 * sa + 1), 8'(2 * sa)});
      got = s_cmd; acc = s_ready;
      @(posedge clk); #1;
      if (acc) sb++;
      if (got) begin
        sa++;
        if (sa == 7) check("s_full_early", s_full, 0);
      end
    end
    check("s_acks", sa, 8);
    check("s_full", s_full, 1);
    check("s_row", s_row, 2);
    check("s_col", s_col, 0);
    cmds = 0;
    for (int c = 0; c < 20; c++) begin
      s_valid = 1; s_byte = 8'($urandom); s_ack = 1;
      @(posedge clk); #1;
      if (s_cmd) cmds++;
    end
    check("s_no_cmd_after_full", cmds, 0);
    check("s_ready_low", s_ready, 0);
    check("s_ovf", s_ovf, 1);
    check("s_row_hold", s_row, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
